// File: rtl/writeback_sequencer.sv
// Multicycle writeback stage: selects the writeback source, aligns and extends loads,
// and drives the register file write port (active-low enable) for exactly one cycle.
module writeback_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SELECT_SIZE = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             wb_src_i,
    input  logic [DATA_WIDTH-1:0]  alu_i,
    input  logic [DATA_WIDTH-1:0]  link_i,
    input  logic [DATA_WIDTH-1:0]  imm_i,
    input  logic [2:0]             funct3_i,
    input  logic [1:0]             byte_off_i,
    input  logic [SELECT_SIZE-1:0] rd_i,
    output logic                   mem_rd_o,
    input  logic                   mem_rdy_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    output logic                   reg_we_o,
    output logic [SELECT_SIZE-1:0] reg_dst_o,
    output logic [DATA_WIDTH-1:0]  reg_data_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_MEM  = 2'b01;
    localparam logic [1:0] SRC_LINK = 2'b10;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, WRITE, FAULT} state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [SELECT_SIZE-1:0] lat_rd, lat_rd_n;
    logic [2:0]             lat_f3, lat_f3_n;
    logic [1:0]             lat_off, lat_off_n;
    logic                   we_n, mem_rd_n, done_n, err_n;
    logic [SELECT_SIZE-1:0] dst_n;
    logic [DATA_WIDTH-1:0]  data_n;

    function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: load_legal = 1'b1;
            3'b001, 3'b101: load_legal = !off[0];
            3'b010:         load_legal = (off == 2'b00);
            default:        load_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [2:0] f3,
                                                          input logic [1:0] off,
                                                          input logic [DATA_WIDTH-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = word[16*off[1] +: 16];
        case (f3)
            3'b000:  extend_load = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b001:  extend_load = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b100:  extend_load = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b101:  extend_load = {{(DATA_WIDTH-16){1'b0}}, h};
            default: extend_load = word;
        endcase
    endfunction

    assign req_ready_o = (state == IDLE) && !reset_i;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        lat_rd_n  = lat_rd;
        lat_f3_n  = lat_f3;
        lat_off_n = lat_off;
        dst_n     = reg_dst_o;
        data_n    = reg_data_o;
        we_n      = 1'b1;
        mem_rd_n  = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    if (wb_src_i == SRC_MEM) begin
                        lat_rd_n  = rd_i;
                        lat_f3_n  = funct3_i;
                        lat_off_n = byte_off_i;
                        if (load_legal(funct3_i, byte_off_i)) begin
                            state_n  = MEM_WAIT;
                            mem_rd_n = 1'b1;
                            cnt_n    = '0;
                        end else begin
                            state_n = FAULT;
                            err_n   = 1'b1;
                            done_n  = 1'b1;
                        end
                    end else begin
                        case (wb_src_i)
                            SRC_ALU:  data_n = alu_i;
                            SRC_LINK: data_n = link_i;
                            default:  data_n = imm_i;
                        endcase
                        dst_n   = rd_i;
                        we_n    = (rd_i == '0);
                        done_n  = 1'b1;
                        state_n = WRITE;
                    end
                end
            end
            MEM_WAIT: begin
                mem_rd_n = 1'b1;
                // A response arriving on the final timeout cycle still wins.
                if (mem_rdy_i) begin
                    data_n   = extend_load(lat_f3, lat_off, mem_data_i);
                    dst_n    = lat_rd;
                    we_n     = (lat_rd == '0);
                    done_n   = 1'b1;
                    mem_rd_n = 1'b0;
                    state_n  = WRITE;
                end else if (cnt == CNT_LAST) begin
                    err_n    = 1'b1;
                    done_n   = 1'b1;
                    mem_rd_n = 1'b0;
                    state_n  = FAULT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WRITE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_rd     <= '0;
            lat_f3     <= '0;
            lat_off    <= '0;
            reg_we_o   <= 1'b1;
            reg_dst_o  <= '0;
            reg_data_o <= '0;
            mem_rd_o   <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lat_rd     <= lat_rd_n;
            lat_f3     <= lat_f3_n;
            lat_off    <= lat_off_n;
            reg_we_o   <= we_n;
            reg_dst_o  <= dst_n;
            reg_data_o <= data_n;
            mem_rd_o   <= mem_rd_n;
            done_o     <= done_n;
            err_o      <= err_n;
        end
    end

endmodule
